// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: ALU ops, instruction fields, hazard FSM states
package cpu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    typedef enum logic {
        HZ_NORMAL = 1'b0,
        HZ_BUBBLE = 1'b1
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard and stall generation
module load_use_detect
    import cpu_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memRead,
    input  logic [4:0] ex_writeReg,
    input  logic       id_valid,
    input  logic       id_useRs,
    input  logic       id_useRt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_flush,
    output logic       hz,
    output logic       stall
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_useRs && (ex_writeReg == rs);
    assign rt_hit = id_useRt && (ex_writeReg == rt);

    // A load targeting $0 produces nothing a consumer could wait on.
    assign hz    = ex_valid && ex_memRead && (ex_writeReg != REG_ZERO) && id_valid && (rs_hit || rt_hit);
    assign stall = hz && !ex_flush;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use bubble insertion
// Optional saturating stall/flush counters are built when HAZARD_CNT_EN is defined.
module id_ex_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_useRs,
    input  logic              id_useRt,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_memToReg,
    input  logic              id_aluSrc,
    input  logic              id_regDst,
    input  logic [3:0]        id_aluOp,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_writeReg,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic              ex_memToReg,
    output logic              ex_aluSrc,
    output logic [3:0]        ex_aluOp
`ifdef HAZARD_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] dest;
    logic       hz;
    hz_state_t  hz_state;
    logic       unused_instr_bits;

    assign rs   = id_instr[RS_HI:RS_LO];
    assign rt   = id_instr[RT_HI:RT_LO];
    assign rd   = id_instr[RD_HI:RD_LO];
    assign dest = id_regDst ? rd : rt;

    assign unused_instr_bits = ^{id_instr[31:26], id_instr[10:0]};

    load_use_detect u_detect (
        .ex_valid    (ex_valid),
        .ex_memRead  (ex_memRead),
        .ex_writeReg (ex_writeReg),
        .id_valid    (id_valid),
        .id_useRs    (id_useRs),
        .id_useRt    (id_useRt),
        .rs          (rs),
        .rt          (rt),
        .ex_flush    (ex_flush),
        .hz          (hz),
        .stall       (stall)
    );

    always_ff @(posedge clock_in) begin
        if (reset || ex_flush || hz) begin
            ex_valid    <= 1'b0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_pc4      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_writeReg <= '0;
            ex_regWrite <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_memToReg <= 1'b0;
            ex_aluSrc   <= 1'b0;
            ex_aluOp    <= '0;
        end else begin
            ex_valid    <= id_valid;
            ex_rs_data  <= readData1;
            ex_rt_data  <= readData2;
            ex_imm      <= id_imm;
            ex_pc4      <= id_pc4;
            ex_rs       <= rs;
            ex_rt       <= rt;
            ex_writeReg <= dest;
            // An empty ID slot must never write state downstream.
            ex_regWrite <= id_regWrite && id_valid;
            ex_memRead  <= id_memRead  && id_valid;
            ex_memWrite <= id_memWrite && id_valid;
            ex_memToReg <= id_memToReg && id_valid;
            ex_aluSrc   <= id_aluSrc;
            ex_aluOp    <= id_aluOp;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            hz_state <= HZ_NORMAL;
        end else begin
            case (hz_state)
                HZ_NORMAL: if (stall) hz_state <= HZ_BUBBLE;
                HZ_BUBBLE: hz_state <= HZ_NORMAL;
                default:   hz_state <= HZ_NORMAL;
            endcase
        end
    end

`ifdef HAZARD_CNT_EN
    always_ff @(posedge clock_in) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (ex_flush && id_valid && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
